axi_csr_responder: RTL and testbench



---
 rtl/axi_csr_responder.sv | 205 ++++++++++++++++++++
 tb/tb_axi_csr_responder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_csr_responder.sv
// AXI4 responder that turns single-outstanding AXI-MM bursts into per-beat
// CSR write strobes and request/response register reads.
module axi_csr_responder #(
    parameter int ID_WIDTH   = 12,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                axi4_mm_clk,
    input  logic                axi4_mm_rst_n,
    input  logic [ID_WIDTH-1:0] awid,
    input  logic [63:0]         awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [511:0]        wdata,
    input  logic [63:0]         wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_WIDTH-1:0] bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_WIDTH-1:0] arid,
    input  logic [63:0]         araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_WIDTH-1:0] rid,
    output logic [511:0]        rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    output logic [23:0]         write_reg_addr,
    output logic [511:0]        write_reg_data,
    output logic [63:0]         write_reg_strb,
    output logic                write_reg_enabled,
    output logic [23:0]         rd_reg_addr,
    output logic                rd_reg_req,
    input  logic [511:0]        rd_reg_data,
    input  logic                rd_reg_valid
);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    localparam int TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, W_DATA, W_RESP, R_REQ, R_WAIT, R_DATA} state_t;
    state_t state, state_nx;

    logic                prio_wr;
    logic [ID_WIDTH-1:0] id;
    logic [23:0]         addr, addr_nx;
    logic [7:0]          len, beat;
    logic [2:0]          size;
    logic [1:0]          burst, err, wresp_acc, wresp_nx;
    logic [TW-1:0]       timer;
    logic                last_beat;

    logic [ID_WIDTH-1:0] ld_id;
    logic [63:0]         ld_addr;
    logic [7:0]          ld_len;
    logic [2:0]          ld_size;
    logic [1:0]          ld_burst, ld_err;

    assign last_beat = (beat == len);
    assign addr_nx   = (burst == 2'b01) ? addr + (24'd1 << size) : addr;
    // A wlast that disagrees with the beat count demotes OKAY to SLVERR only.
    assign wresp_nx  = ((last_beat != wlast) && (wresp_acc == OKAY)) ? SLVERR : wresp_acc;

    always_comb begin
        ld_id    = awready ? awid    : arid;
        ld_addr  = awready ? awaddr  : araddr;
        ld_len   = awready ? awlen   : arlen;
        ld_size  = awready ? awsize  : arsize;
        ld_burst = awready ? awburst : arburst;
        if (ld_addr[63:24] != '0)
            ld_err = DECERR;
        else if (ld_burst[1])
            ld_err = SLVERR;
        else
            ld_err = OKAY;
    end

    always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
        if (!axi4_mm_rst_n) state <= IDLE;
        else                state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        awready  = 1'b0;
        arready  = 1'b0;
        wready   = (state == W_DATA);
        bvalid   = (state == W_RESP);
        rvalid   = (state == R_DATA);
        case (state)
            IDLE: begin
                awready = axi4_mm_rst_n && awvalid && (!arvalid || prio_wr);
                arready = axi4_mm_rst_n && arvalid && !awready;
                if (awready)      state_nx = W_DATA;
                else if (arready) state_nx = R_REQ;
            end
            W_DATA: if (wvalid && last_beat) state_nx = W_RESP;
            W_RESP: if (bready) state_nx = IDLE;
            R_REQ:  state_nx = (err != OKAY) ? R_DATA : R_WAIT;
            R_WAIT: if (rd_reg_valid || timer == TO_LAST) state_nx = R_DATA;
            R_DATA: if (rready) state_nx = rlast ? IDLE : R_REQ;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
        if (!axi4_mm_rst_n) begin
            prio_wr           <= 1'b1;
            id                <= '0;
            addr              <= '0;
            len               <= '0;
            beat              <= '0;
            size              <= '0;
            burst             <= '0;
            err               <= OKAY;
            wresp_acc         <= OKAY;
            timer             <= '0;
            bid               <= '0;
            bresp             <= OKAY;
            rid               <= '0;
            rdata             <= '0;
            rresp             <= OKAY;
            rlast             <= 1'b0;
            write_reg_addr    <= '0;
            write_reg_data    <= '0;
            write_reg_strb    <= '0;
            write_reg_enabled <= 1'b0;
            rd_reg_addr       <= '0;
            rd_reg_req        <= 1'b0;
        end else begin
            write_reg_enabled <= 1'b0;
            rd_reg_req        <= 1'b0;
            case (state)
                IDLE: if (awready || arready) begin
                    prio_wr   <= !prio_wr;
                    id        <= ld_id;
                    addr      <= ld_addr[23:0];
                    len       <= ld_len;
                    size      <= ld_size;
                    burst     <= ld_burst;
                    beat      <= '0;
                    err       <= ld_err;
                    wresp_acc <= ld_err;
                end
                W_DATA: if (wvalid) begin
                    // Errored bursts are drained without touching the CSRs.
                    if (err == OKAY) begin
                        write_reg_addr    <= addr;
                        write_reg_data    <= wdata;
                        write_reg_strb    <= wstrb;
                        write_reg_enabled <= 1'b1;
                    end
                    wresp_acc <= wresp_nx;
                    if (last_beat) begin
                        bid   <= id;
                        bresp <= wresp_nx;
                    end else begin
                        beat <= beat + 8'd1;
                        addr <= addr_nx;
                    end
                end
                R_REQ: begin
                    rid   <= id;
                    rlast <= last_beat;
                    timer <= '0;
                    if (err != OKAY) begin
                        rdata <= '0;
                        rresp <= err;
                    end else begin
                        rd_reg_req  <= 1'b1;
                        rd_reg_addr <= addr;
                    end
                end
                R_WAIT: begin
                    if (rd_reg_valid) begin
                        rdata <= rd_reg_data;
                        rresp <= OKAY;
                    end else if (timer == TO_LAST) begin
                        rdata <= '0;
                        rresp <= SLVERR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                R_DATA: if (rready && !rlast) begin
                    beat <= beat + 8'd1;
                    addr <= addr_nx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_csr_responder.sv
// Directed bench for axi_csr_responder: AXI master tasks, strobe monitor and
// a latency-programmable register-file model.
module tb_axi_csr_responder;
    localparam int IDW = 12;
    localparam int TO  = 255;

    logic           clk = 1'b0, rst_n = 1'b0;
    logic [IDW-1:0] awid = '0, arid = '0, bid, rid;
    logic [63:0]    awaddr = '0, araddr = '0, wstrb = '0, write_reg_strb;
    logic [7:0]     awlen = '0, arlen = '0;
    logic [2:0]     awsize = '0, arsize = '0;
    logic [1:0]     awburst = '0, arburst = '0, bresp, rresp;
    logic           awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic           bready = 1'b0, rready = 1'b0, rd_reg_valid = 1'b0;
    logic           awready, arready, wready, bvalid, rvalid, rlast, write_reg_enabled, rd_reg_req;
    logic [511:0]   wdata = '0, rdata, write_reg_data, rd_reg_data = '0;
    logic [23:0]    write_reg_addr, rd_reg_addr;

    always #5 clk = ~clk;

    axi_csr_responder #(.ID_WIDTH(IDW), .RD_TIMEOUT(TO)) dut (
        .axi4_mm_clk(clk), .axi4_mm_rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
        .write_reg_strb(write_reg_strb), .write_reg_enabled(write_reg_enabled),
        .rd_reg_addr(rd_reg_addr), .rd_reg_req(rd_reg_req),
        .rd_reg_data(rd_reg_data), .rd_reg_valid(rd_reg_valid)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] rf_val(input logic [23:0] a);
        return {16{8'hC3, a}};
    endfunction

    // Strobe monitor
    logic [23:0]  s_addr[$];
    logic [511:0] s_data[$];
    logic [63:0]  s_strb[$];
    always @(posedge clk) begin
        #1;
        if (write_reg_enabled) begin
            s_addr.push_back(write_reg_addr);
            s_data.push_back(write_reg_data);
            s_strb.push_back(write_reg_strb);
        end
    end

    // Register file: answers rf_lat cycles after the request; rf_lat < 1 never answers
    int          rf_lat = 1, rf_cnt = 0;
    bit          rf_pend = 0;
    logic [23:0] rf_addr = '0;
    logic [23:0] req_q[$];
    always @(posedge clk) begin
        #1;
        rd_reg_valid = 1'b0;
        if (!rst_n) rf_pend = 0;
        else begin
            if (rf_pend) begin
                if (rf_cnt == 0) begin
                    rd_reg_valid = 1'b1;
                    rd_reg_data  = rf_val(rf_addr);
                    rf_pend      = 0;
                end else rf_cnt--;
            end
            if (rd_reg_req) begin
                req_q.push_back(rd_reg_addr);
                if (rf_lat >= 1) begin
                    rf_pend = 1;
                    rf_cnt  = rf_lat - 1;
                    rf_addr = rd_reg_addr;
                end
            end
        end
    end

    logic [IDW-1:0] got_bid;
    logic [1:0]     got_bresp;
    logic [511:0]   r_data[4], r_first;
    logic [1:0]     r_resp[4];
    logic           r_last[4], r_held_valid;
    logic [IDW-1:0] r_id[4];
    int             r_wait[4];

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic aw_phase(input logic [IDW-1:0] id, input logic [63:0] a, input logic [7:0] l,
                            input logic [2:0] s, input logic [1:0] b);
        int n = 0;
        awid = id; awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1;
        #1;
        while (!awready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("aw_timeout", 0, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [511:0] d, input logic [63:0] s, input logic l);
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        while (!wready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("w_timeout", 0, 1);
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_phase();
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("b_timeout", 0, 1);
        got_bid = bid; got_bresp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    // wl_mode: 0 correct wlast, 1 extra wlast on beat 0, 2 wlast missing on final beat
    task automatic wr(input logic [IDW-1:0] id, input logic [63:0] a, input logic [7:0] l,
                      input logic [2:0] s, input logic [1:0] b, input logic [511:0] d0,
                      input int wl_mode);
        logic wl;
        aw_phase(id, a, l, s, b);
        for (int i = 0; i <= int'(l); i++) begin
            wl = (i == int'(l));
            if (wl_mode == 1 && i == 0)      wl = 1'b1;
            if (wl_mode == 2 && i == int'(l)) wl = 1'b0;
            w_beat(d0 + 512'(i), '1, wl);
        end
        b_phase();
    endtask

    task automatic rd(input logic [IDW-1:0] id, input logic [63:0] a, input logic [7:0] l,
                      input logic [2:0] s, input logic [1:0] b, input int hold);
        int n;
        arid = id; araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
        n = 0;
        #1;
        while (!arready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("ar_timeout", 0, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i <= int'(l) && i < 4; i++) begin
            rready = 1'b0;
            n = 0;
            while (!rvalid && n < 1000) begin @(posedge clk); #1; n++; end
            if (n >= 1000) chk("r_timeout", 0, 1);
            r_wait[i] = n;
            r_first = rdata;
            if (i == 0) repeat (hold) begin @(posedge clk); #1; end
            r_held_valid = rvalid;
            r_data[i] = rdata; r_resp[i] = rresp; r_last[i] = rlast; r_id[i] = rid;
            rready = 1'b1;
            @(posedge clk); #1;
            rready = 1'b0;
        end
    endtask

    task automatic clr();
        s_addr.delete(); s_data.delete(); s_strb.delete(); req_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int seen;
        // Reset state, with awvalid asserted to confirm ready is held off
        awvalid = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rst_ctl", {awready, arready, wready, bvalid, rvalid, rlast, write_reg_enabled, rd_reg_req}, 0);
        chk("rst_ids", {bid, rid, bresp, rresp}, 0);
        chk("rst_wr", {write_reg_addr, write_reg_strb, rd_reg_addr}, 0);
        chk("rst_data", write_reg_data | rdata, 0);
        awvalid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // AW and AR together, twice: write wins each time, then the read
        rf_lat = 1;
        for (int k = 0; k < 2; k++) begin
            clr();
            arid = 12'h300 + 12'(k); araddr = 64'h4000 + 64'(k * 64); arlen = 0; arsize = 6; arburst = 1;
            arvalid = 1'b1;
            awid = 12'h200 + 12'(k); awaddr = 64'h5000; awlen = 0; awsize = 6; awburst = 1;
            awvalid = 1'b1;
            #1;
            chk("arb_awready", awready, 1);
            chk("arb_arready", arready, 0);
            wr(12'h200 + 12'(k), 64'h5000, 0, 6, 1, 512'h77, 0);
            chk("arb_wr_strobes", s_addr.size(), 1);
            chk("arb_no_rd_yet", req_q.size(), 0);
            chk("arb_bid", got_bid, 12'h200 + 12'(k));
            rd(12'h300 + 12'(k), 64'h4000 + 64'(k * 64), 0, 6, 1, (k == 0) ? 5 : 0);
            chk("arb_rdata", r_data[0], rf_val(24'h4000 + 24'(k * 64)));
            chk("arb_rid", r_id[0], 12'h300 + 12'(k));
            if (k == 0) begin
                chk("hold_first", r_first, rf_val(24'h4000));
                chk("hold_valid", r_held_valid, 1);
            end
        end

        // Single write
        clr();
        wr(12'h05A, 64'h9000, 0, 6, 1, 512'h0, 0);
        chk("w1_count", s_addr.size(), 1);
        chk("w1_addr", s_addr[0], 24'h9000);
        chk("w1_data", s_data[0], 0);
        chk("w1_strb", s_strb[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("w1_bid", got_bid, 12'h05A);
        chk("w1_bresp", got_bresp, 2'b00);

        // INCR two beats
        clr();
        wr(12'h011, 64'h8500, 1, 6, 1, {16{32'hDEAD0000}}, 0);
        chk("w2_count", s_addr.size(), 2);
        chk("w2_addr0", s_addr[0], 24'h8500);
        chk("w2_addr1", s_addr[1], 24'h8540);
        chk("w2_data1", s_data[1], {16{32'hDEAD0000}} + 512'd1);
        chk("w2_bresp", got_bresp, 2'b00);

        // Early wlast on beat 0
        clr();
        wr(12'h012, 64'h8500, 1, 6, 1, 512'h5, 1);
        chk("w_early_count", s_addr.size(), 2);
        chk("w_early_bresp", got_bresp, 2'b10);

        // wlast missing on the final beat
        clr();
        wr(12'h013, 64'h8500, 1, 6, 1, 512'h5, 2);
        chk("w_nolast_count", s_addr.size(), 2);
        chk("w_nolast_bresp", got_bresp, 2'b10);

        // FIXED burst holds the address
        clr();
        wr(12'h014, 64'h0200, 1, 6, 0, 512'h9, 0);
        chk("w_fixed_addr0", s_addr[0], 24'h000200);
        chk("w_fixed_addr1", s_addr[1], 24'h000200);

        // INCR wraps at 2^24
        clr();
        wr(12'h015, 64'hFF_FFC0, 1, 6, 1, 512'h9, 0);
        chk("w_wrap24_addr1", s_addr[1], 24'h000000);

        // WRAP burst type is rejected
        clr();
        wr(12'h016, 64'h0400, 1, 6, 2, 512'h9, 0);
        chk("w_wrapburst_count", s_addr.size(), 0);
        chk("w_wrapburst_bresp", got_bresp, 2'b10);

        // Out-of-range address: DECERR both ways
        clr();
        wr(12'h017, 64'h1_0000_0000, 0, 6, 1, 512'hABC, 0);
        chk("w_dec_count", s_addr.size(), 0);
        chk("w_dec_bresp", got_bresp, 2'b11);
        rd(12'h018, 64'h1_0000_0000, 0, 6, 1, 0);
        chk("r_dec_data", r_data[0], 0);
        chk("r_dec_resp", r_resp[0], 2'b11);
        chk("r_dec_last", r_last[0], 1);
        chk("r_dec_noreq", req_q.size(), 0);

        // INCR read, register file answers 2 cycles after request
        clr();
        rf_lat = 2;
        rd(12'h0F0, 64'hF000, 2, 6, 1, 0);
        chk("r3_reqs", req_q.size(), 3);
        chk("r3_req2", req_q[2], 24'hF080);
        for (int i = 0; i < 3; i++) begin
            chk("r3_data", r_data[i], rf_val(24'hF000 + 24'(i * 64)));
            chk("r3_last", r_last[i], (i == 2) ? 1 : 0);
            chk("r3_resp", r_resp[i], 2'b00);
            chk("r3_rid", r_id[i], 12'h0F0);
        end

        // Register file never answers
        clr();
        rf_lat = 0;
        rd(12'h0E0, 64'h0100, 0, 6, 1, 0);
        chk("to_wait_min", r_wait[0] >= TO, 1);
        chk("to_wait_max", r_wait[0] <= TO + 2, 1);
        chk("to_data", r_data[0], 0);
        chk("to_resp", r_resp[0], 2'b10);
        rf_lat = 1;

        // Reset in the middle of a write burst
        clr();
        aw_phase(12'h0AB, 64'h3000, 3, 6, 1);
        w_beat(512'h1234, '1, 1'b0);
        chk("mid_pre_strobe", write_reg_enabled, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {awready, arready, wready, bvalid, rvalid, write_reg_enabled, rd_reg_req}, 0);
        chk("mid_rst_wr", {write_reg_addr, write_reg_strb}, 0);
        chk("mid_rst_wdata", write_reg_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bvalid || wready || rvalid) seen++;
        end
        chk("post_rst_quiet", seen, 0);

        // Normal operation after the abort
        clr();
        wr(12'h0CD, 64'h9000, 0, 6, 1, 512'h42, 0);
        chk("post_rst_count", s_addr.size(), 1);
        chk("post_rst_data", s_data[0], 512'h42);
        chk("post_rst_bresp", got_bresp, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
